// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the fetch/decode slice.
// Widths, address-field rule and the opcode enum.
package instr_pkg;

  localparam int INSTR_WIDTH_DEF  = 32;
  localparam int OPCODE_WIDTH_DEF = 4;

  // Target-address field is everything below the opcode.
  function automatic int addr_width(input int iw, input int ow);
    return iw - ow;
  endfunction

  localparam int ADDR_WIDTH_DEF =
    addr_width(INSTR_WIDTH_DEF, OPCODE_WIDTH_DEF);

  typedef enum logic [OPCODE_WIDTH_DEF-1:0] {
    OP_NOP    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_ADD    = 4'h3,
    OP_SUB    = 4'h4,
    OP_AND    = 4'h5,
    OP_OR     = 4'h6,
    OP_LDI    = 4'h7,
    OP_JUMP   = 4'h8,
    OP_BRANCH = 4'h9,
    OP_HALT   = 4'hf
  } opcode_e;

endpackage

// File: rtl/instr_queue_storage.sv
// DEPTH x WIDTH register array: one write port, async read port.
// Ports: clock, we/waddr/wdata (write), raddr/rdata (read).
module instr_queue_storage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: stale words are masked by out_valid upstream.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue_register.sv
// Instruction FIFO between fetch and decode, head split into fields.
// Ports: clock, reset, push side (register_input/in_valid/in_ready), flush, pop side (out_valid/out_ready/opcode/target_address), count.
module instruction_queue_register
  import instr_pkg::*;
#(
  parameter int INSTR_WIDTH  = INSTR_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int DEPTH        = 4,
  parameter int AW = addr_width(INSTR_WIDTH, OPCODE_WIDTH),
  parameter int PW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [INSTR_WIDTH-1:0]  register_input,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [AW-1:0]           target_address,
  output logic [CW-1:0]           count
);

  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [INSTR_WIDTH-1:0] head;
  logic                   push;
  logic                   pop;

  // count alone decides full/empty; pointers may be equal in both.
  assign in_ready  = !reset && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is free.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  instr_queue_storage #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clock (clock),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (register_input),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign opcode = out_valid
    ? head[INSTR_WIDTH-1 -: OPCODE_WIDTH] : '0;
  assign target_address = out_valid
    ? head[AW-1:0] : '0;

endmodule

// File: tb/tb_instruction_queue_register.sv
// Randomised + directed bench for instruction_queue_register.
// Reference model is a plain SV queue per instance.
module tb_instruction_queue_register;

  logic        clock;
  logic        reset;
  logic [31:0] register_input;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [27:0] target_address;
  logic [2:0]  count;

  logic        p_reset;
  logic [15:0] p_input;
  logic        p_in_valid;
  logic        p_in_ready;
  logic        p_flush;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [5:0]  p_opcode;
  logic [9:0]  p_target;
  logic [3:0]  p_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] q  [$];
  logic [15:0] pq [$];

  instruction_queue_register dut (
    .clock          (clock),
    .reset          (reset),
    .register_input (register_input),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .opcode         (opcode),
    .target_address (target_address),
    .count          (count)
  );

  instruction_queue_register #(
    .INSTR_WIDTH  (16),
    .OPCODE_WIDTH (6),
    .DEPTH        (8)
  ) dut_p (
    .clock          (clock),
    .reset          (p_reset),
    .register_input (p_input),
    .in_valid       (p_in_valid),
    .in_ready       (p_in_ready),
    .flush          (p_flush),
    .out_valid      (p_out_valid),
    .out_ready      (p_out_ready),
    .opcode         (p_opcode),
    .target_address (p_target),
    .count          (p_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge, updating the queue models from the spec rules.
  task automatic tick();
    bit pu;
    bit po;
    pu = in_valid && !reset && (q.size() < 4);
    po = out_ready && (q.size() != 0);
    if (reset || flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(register_input);
    end
    pu = p_in_valid && !p_reset && (pq.size() < 8);
    po = p_out_ready && (pq.size() != 0);
    if (p_reset || p_flush) pq.delete();
    else begin
      if (po) void'(pq.pop_front());
      if (pu) pq.push_back(p_input);
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mhead();
    return (q.size() != 0) ? q[0] : 32'h0;
  endfunction

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    register_input = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] h;
    reset = 1'b1;
    idle();
    register_input = '0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || count !== 3'd0
        || out_valid !== 1'b0)
      begin
        errors++;
        $display("FAIL reset_hold: rdy=%b cnt=%0d vld=%b want 0 0 0",
                 in_ready, count, out_valid);
      end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || opcode !== 4'h0
        || target_address !== 28'h0)
      begin
        errors++;
        $display("FAIL reset_idle: rdy=%b op=%h ta=%h want 1 0 0",
                 in_ready, opcode, target_address);
      end
    push_word(32'hA5F01234);
    h = mhead();
    checks++;
    if (out_valid !== 1'b1 || opcode !== 4'hA
        || target_address !== 28'h5F01234 || count !== 3'd1
        || opcode !== h[31:28])
      begin
        errors++;
        $display("FAIL single_push: vld=%b op=%h ta=%h cnt=%0d want 1 a 5f01234 1",
                 out_valid, opcode, target_address, count);
      end
  endtask

  task automatic test_fill();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 1; i <= 4; i++)
      push_word({4'(i), 24'h0, 4'(i)});
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL fill_full: cnt=%0d rdy=%b want 4 0",
                 count, in_ready);
      end
    register_input = 32'hB1234567;
    in_valid = 1'b1;
    tick();
    checks++;
    if (count !== 3'd4 || target_address !== 28'h0000001)
      begin
        errors++;
        $display("FAIL fill_held: cnt=%0d ta=%h want 4 0000001",
                 count, target_address);
      end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd3 || opcode !== 4'h2
        || target_address !== 28'h0000002
        || in_ready !== 1'b1)
      begin
        errors++;
        $display("FAIL fill_pop: cnt=%0d op=%h ta=%h rdy=%b want 3 2 0000002 1",
                 count, opcode, target_address, in_ready);
      end
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || q[3] !== 32'hB1234567)
      begin
        errors++;
        $display("FAIL fill_late_push: cnt=%0d want 4", count);
      end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_word(32'h11111111);
    push_word(32'h22222222);
    register_input = 32'hC0000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd2 || opcode !== 4'h2)
      begin
        errors++;
        $display("FAIL b2b_count: cnt=%0d op=%h want 2 2",
                 count, opcode);
      end
    tick();
    h = mhead();
    checks++;
    if (count !== 3'd1 || opcode !== 4'hC
        || {opcode, target_address} !== h)
      begin
        errors++;
        $display("FAIL b2b_last: cnt=%0d word=%h want 1 %h",
                 count, {opcode, target_address}, h);
      end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || opcode !== 4'h0)
      begin
        errors++;
        $display("FAIL b2b_drained: vld=%b op=%h want 0 0",
                 out_valid, opcode);
      end
  endtask

  task automatic test_wrap();
    int bad = 0;
    logic [31:0] got;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_word(32'(i));
      got = {opcode, target_address};
      if (out_valid !== 1'b1 || got !== 32'(i)
          || count !== 3'd1) bad++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (count !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0)
      begin
        errors++;
        $display("FAIL wrap_order: bad=%0d want 0", bad);
      end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++)
      push_word(32'h30000000 + 32'(i));
    register_input = 32'hF0000000;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0
        || opcode !== 4'h0)
      begin
        errors++;
        $display("FAIL flush_clear: cnt=%0d vld=%b op=%h want 0 0 0",
                 count, out_valid, opcode);
      end
    push_word(32'h70000007);
    checks++;
    if (opcode !== 4'h7 || target_address !== 28'h7
        || count !== 3'd1)
      begin
        errors++;
        $display("FAIL flush_repush: op=%h ta=%h cnt=%0d want 7 7 1",
                 opcode, target_address, count);
      end
  endtask

  task automatic test_reset_mid();
    push_word(32'h81111111);
    push_word(32'h92222222);
    checks++;
    if (count !== 3'd3)
      begin
        errors++;
        $display("FAIL mid_setup: cnt=%0d want 3", count);
      end
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    register_input = 32'hEEEEEEEE;
    tick();
    idle();
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0
        || target_address !== 28'h0 || in_ready !== 1'b1)
      begin
        errors++;
        $display("FAIL mid_reset: cnt=%0d vld=%b ta=%h rdy=%b want 0 0 0 1",
                 count, out_valid, target_address, in_ready);
      end
  endtask

  task automatic test_random();
    int bad = 0;
    bit hold = 0;
    logic [31:0] h;
    for (int c = 0; c < 400; c++) begin
      if (!hold) register_input = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0)
                  || (c > 200 && $urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 79) == 0);
      hold  = in_valid && !in_ready;
      tick();
      h = mhead();
      if (count !== 3'(q.size())
          || out_valid !== (q.size() != 0)
          || in_ready !== (!reset && q.size() < 4)
          || opcode !== h[31:28]
          || target_address !== h[27:0])
        begin
          bad++;
          if (bad < 4)
            $display("FAIL rand_cycle%0d: cnt=%0d word=%h want %0d %h",
                     c, count, {opcode, target_address},
                     q.size(), h);
        end
    end
    idle();
    reset = 1'b0;
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_param();
    int bad = 0;
    logic [15:0] exp;
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    p_input = 16'hFC01;
    p_in_valid = 1'b1;
    tick();
    p_in_valid = 1'b0;
    checks++;
    if (p_opcode !== 6'h3F || p_target !== 10'h001
        || p_count !== 4'd1)
      begin
        errors++;
        $display("FAIL param_fields: op=%h ta=%h cnt=%0d want 3f 001 1",
                 p_opcode, p_target, p_count);
      end
    for (int i = 0; i < 8; i++) begin
      p_input = 16'($urandom);
      p_in_valid = 1'b1;
      tick();
    end
    p_in_valid = 1'b0;
    checks++;
    if (p_count !== 4'd8 || p_in_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL param_full: cnt=%0d rdy=%b want 8 0",
                 p_count, p_in_ready);
      end
    p_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = pq[0];
      if ({p_opcode, p_target} !== exp
          || p_out_valid !== 1'b1) bad++;
      tick();
    end
    p_out_ready = 1'b0;
    checks++;
    if (bad != 0 || p_count !== 4'd0)
      begin
        errors++;
        $display("FAIL param_order: bad=%0d cnt=%0d want 0 0",
                 bad, p_count);
      end
  endtask

  initial begin
    p_reset     = 1'b1;
    p_input     = '0;
    p_in_valid  = 1'b0;
    p_flush     = 1'b0;
    p_out_ready = 1'b0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
